// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  // Default number of data bits per frame.
  localparam int DATA_WIDTH_DEF = 8;

  // Legal oversampling ratios.
  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  // Receive frame phases.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter.
// edge_count runs 0..prescale-1 while enabled. bit_count advances on each wrap.
// clr_i takes priority over en_i and zeroes both counters.
module edge_bit_counter #(
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [5:0]           prescale_i,
  output logic [5:0]           edge_count_o,
  output logic [BIT_CNT_W-1:0] bit_count_o,
  output logic                 end_o
);

  logic [5:0]           edge_q, edge_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;

  assign end_o        = (edge_q == prescale_i - 6'd1);
  assign edge_count_o = edge_q;
  assign bit_count_o  = bit_q;

  // Next-count logic: clear, hold, advance the edge, or wrap and advance the bit.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (end_o) begin
        edge_d = '0;
        bit_d  = bit_q + 1'b1;
      end else begin
        edge_d = edge_q + 6'd1;
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only.
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM.
// Follows each frame through start, data, optional parity and stop. Drives the
// sampler, deserializer and checker enables. Pulses data_valid for one cycle
// after an error-free frame.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BIT_CNT_W  = $clog2(DATA_WIDTH + 3)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic [5:0]           Prescale,
  input  logic                 strt_glitch,
  input  logic                 par_err,
  input  logic                 stp_err,
  output logic [5:0]           edge_count,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic                 dat_samp_en,
  output logic                 deser_en,
  output logic                 strt_chk_en,
  output logic                 par_chk_en,
  output logic                 stp_chk_en,
  output logic                 data_valid
);

  rx_state_e state_q, state_d;
  logic      par_err_q, par_err_d;
  logic      data_valid_d;
  logic      cnt_en, cnt_clr, bit_end;
  logic      last_data;

  edge_bit_counter #(
    .BIT_CNT_W (BIT_CNT_W)
  ) u_counter (
    .clk          (CLK),
    .rst_n        (RST),
    .en_i         (cnt_en),
    .clr_i        (cnt_clr),
    .prescale_i   (Prescale),
    .edge_count_o (edge_count),
    .bit_count_o  (bit_count),
    .end_o        (bit_end)
  );

  assign last_data = (bit_count == BIT_CNT_W'(DATA_WIDTH));

  // Next-state decode. The idle cycle that sees the start edge counts as edge 0,
  // so the counters run in that cycle and START begins at edge 1.
  always_comb begin
    state_d      = state_q;
    par_err_d    = par_err_q;
    data_valid_d = 1'b0;
    cnt_en       = 1'b1;
    cnt_clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = RX_IN;
        if (!RX_IN) state_d = START;
      end
      START: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d   = IDLE;
            cnt_clr   = 1'b1;
            par_err_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end && last_data) state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) begin
          par_err_d = par_err;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          data_valid_d = !stp_err && !par_err_q;
          par_err_d    = 1'b0;
          cnt_clr      = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clr   = 1'b1;
        par_err_d = 1'b0;
      end
    endcase
  end

  // State register. The enables are registered from the next state, so they
  // match the current state with no extra latency.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      par_err_q   <= 1'b0;
      data_valid  <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
    end else begin
      state_q     <= state_d;
      par_err_q   <= par_err_d;
      data_valid  <= data_valid_d;
      dat_samp_en <= (state_d != IDLE);
      strt_chk_en <= (state_d == START);
      deser_en    <= (state_d == DATA);
      par_chk_en  <= (state_d == PARITY);
      stp_chk_en  <= (state_d == STOP);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl.
// Each frame is driven cycle by cycle. Every cycle's outputs are compared with
// values computed from the cycle offset since start-bit detection.
module tb_uart_rx_ctrl;

  localparam int DW  = 8;
  localparam int BCW = $clog2(DW + 3);

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           RX_IN = 1'b1;
  logic           PAR_EN = 1'b0;
  logic [5:0]     Prescale = 6'd8;
  logic           strt_glitch = 1'b0;
  logic           par_err = 1'b0;
  logic           stp_err = 1'b0;
  logic [5:0]     edge_count;
  logic [BCW-1:0] bit_count;
  logic           dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic           data_valid;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_count  (edge_count),
    .bit_count   (bit_count),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  always #5 CLK = ~CLK;

  int          errors = 0;
  int          checks = 0;
  bit          dv_pending = 1'b0;
  logic [DW-1:0] last_byte = '0;
  logic [DW-1:0] shreg = '0;
  int          cyc = 0;
  int          dv_cyc[$];

  // Downstream deserializer stand-in, plus a log of data_valid cycles.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (deser_en && edge_count == Prescale - 6'd1) shreg <= {RX_IN, shreg[DW-1:1]};
    if (data_valid) dv_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({edge_count, bit_count, dat_samp_en, deser_en, strt_chk_en,
                par_chk_en, stp_chk_en, data_valid});
  endfunction

  // Expected outputs at cycle k after detection (k=0 is the idle detection cycle).
  // Enable order: {samp, deser, strt, par, stp}.
  function automatic logic [31:0] expv(input int k, input int p, input bit pe, input bit dv);
    logic [5:0]     ev;
    logic [BCW-1:0] bv;
    logic [4:0]     en;
    int             b;
    ev = '0;
    bv = '0;
    en = '0;
    if (k > 0) begin
      b  = k / p;
      ev = 6'(k % p);
      bv = BCW'(b);
      if (b == 0)                 en = 5'b10100;
      else if (b <= DW)           en = 5'b11000;
      else if (pe && b == DW + 1) en = 5'b10010;
      else                        en = 5'b10001;
    end
    return 32'({ev, bv, en, dv});
  endfunction

  task automatic tick_check(input string tag, input logic [31:0] exp);
    @(negedge CLK);
    check(tag, obs(), exp);
    if (exp[0]) check({tag, "_pdata"}, 32'(shreg), 32'(last_byte));
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      RX_IN       = 1'b1;
      RST         = 1'b1;
      strt_glitch = 1'($urandom);
      par_err     = 1'($urandom);
      stp_err     = 1'($urandom);
      tick_check($sformatf("idle%0d", i), expv(0, 8, 1'b0, dv_pending));
      dv_pending = 1'b0;
    end
  endtask

  // Drive one frame. abort_k >= 0 pulses reset during that cycle.
  task automatic frame(input string tag, input int p, input bit pe, input logic [DW-1:0] d,
                       input bit glitch, input bit perr, input bit serr, input int abort_k);
    int len_full, n, b;
    len_full = (DW + 2 + int'(pe)) * p;
    n        = glitch ? p : ((abort_k >= 0) ? abort_k + 1 : len_full);
    Prescale = 6'(p);
    PAR_EN   = pe;
    for (int k = 0; k < n; k++) begin
      b = k / p;
      if (glitch)                 RX_IN = (k < 2) ? 1'b0 : 1'b1;
      else if (b == 0)            RX_IN = 1'b0;
      else if (b <= DW)           RX_IN = d[b-1];
      else if (pe && b == DW + 1) RX_IN = ^d;
      else                        RX_IN = 1'b1;
      strt_glitch = (k == p - 1) ? glitch : 1'($urandom);
      par_err     = (pe && k == (DW + 2) * p - 1) ? perr : 1'($urandom);
      stp_err     = (k == len_full - 1) ? serr : 1'($urandom);
      RST         = (k == abort_k) ? 1'b0 : 1'b1;
      tick_check($sformatf("%s_k%0d", tag, k), expv(k, p, pe, (k == 0) && dv_pending));
      if (k == 0) dv_pending = 1'b0;
    end
    RST = 1'b1;
    if (!glitch && abort_k < 0 && !(pe && perr) && !serr) begin
      dv_pending = 1'b1;
      last_byte  = d;
    end
  endtask

  initial begin
    int n0, p, len, ak, sel;
    bit pe, gl, pr, sr;

    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("reset", obs(), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(3);

    frame("clean", 8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    frame("nopar", 16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    frame("glitch", 8, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, -1);
    idle(3);
    frame("perr", 8, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0, -1);
    idle(2);
    frame("serr", 8, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, -1);
    idle(2);

    n0 = dv_cyc.size();
    frame("b2b_a", 32, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
    frame("b2b_b", 32, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    check("b2b_count", 32'(dv_cyc.size() - n0), 32'd2);
    if (dv_cyc.size() >= n0 + 2) check("b2b_gap", 32'(dv_cyc[n0+1] - dv_cyc[n0]), 32'd320);

    frame("abort", 8, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 4 * 8 + 3);
    idle(2);
    frame("after_rst", 8, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    for (int f = 0; f < 40; f++) begin
      sel = int'($urandom_range(0, 2));
      p   = (sel == 0) ? 8 : ((sel == 1) ? 16 : 32);
      pe  = 1'($urandom);
      gl  = ($urandom_range(0, 7) == 0);
      pr  = ($urandom_range(0, 7) == 0);
      sr  = ($urandom_range(0, 7) == 0);
      len = (DW + 2 + int'(pe)) * p;
      ak  = (!gl && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      frame($sformatf("rnd%0d", f), p, pe, 8'($urandom), gl, pr, sr, ak);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side control FSM for the UART RX path, with an integrated edge/bit counter.
- Detects the start bit, times each bit period in Prescale oversampling clocks, and tracks the frame through start, data, optional parity and stop.
- Drives the enables of the data sampler, the deserializer and the start/parity/stop checkers.
- Pulses data_valid when a frame completes without errors.
- Sits directly upstream of the deserializer and supplies its Enable and edge_count.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (LSB first).
- BIT_CNT_W, $clog2(DATA_WIDTH+3), width of bit_count.

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  reset. Synchronous, active-low.
- RX_IN  input  1  serial line, idle high (already synchronised upstream).
- PAR_EN  input  1  1 = a parity bit follows the data.
- Prescale  input  6  oversampling ratio. Legal values: 8, 16, 32.
- strt_glitch  input  1  from start checker; valid at edge Prescale-1 of START.
- par_err  input  1  from parity checker; valid at edge Prescale-1 of PARITY.
- stp_err  input  1  from stop checker; valid at edge Prescale-1 of STOP.
- edge_count  output  6  oversampling edge index within the current bit.
- bit_count  output  BIT_CNT_W  bit index in frame: 0 = start, 1..DATA_WIDTH = data, then parity/stop.
- dat_samp_en  output  1  data sampler enable.
- deser_en  output  1  deserializer Enable.
- strt_chk_en  output  1  start checker enable.
- par_chk_en  output  1  parity checker enable.
- stp_chk_en  output  1  stop checker enable.
- data_valid  output  1  one-cycle pulse; deserializer P_DATA is a valid frame.

Behaviour:
Reset
- RST low at a clock edge forces: state IDLE, edge_count=0, bit_count=0, par_err_q=0, all outputs 0.
- Reset mid-frame aborts the frame; no data_valid is generated.

States: IDLE, START, DATA, PARITY, STOP (Moore).
- Enables are decoded from the state register with no added latency.
- dat_samp_en = 1 in every state except IDLE.
- strt_chk_en = START; deser_en = DATA; par_chk_en = PARITY; stp_chk_en = STOP.

Counters
- END = (edge_count == Prescale-1).
- Outside IDLE, edge_count increments every cycle and wraps to 0 at END.
- bit_count increments on every END.
- In IDLE both counters are held at 0.

Transitions
- IDLE: RX_IN==0 -> START next cycle, with edge_count=1. The detection cycle counts as edge 0.
- START at END:
  - strt_glitch=1 -> IDLE, counters cleared.
  - otherwise -> DATA, bit_count=1.
- DATA at END with bit_count==DATA_WIDTH: -> PARITY if PAR_EN, else -> STOP.
- PARITY at END: capture par_err into par_err_q, then -> STOP.
- STOP at END: -> IDLE.
  - If !stp_err and !par_err_q, data_valid=1 in the following cycle (registered, exactly one cycle).
  - par_err_q is cleared on entry to IDLE.

Frame timing
- A frame lasts (DATA_WIDTH+2+PAR_EN)*Prescale cycles from the detection cycle.
- data_valid rises the cycle after the final stop edge.

Back-to-back frames
- RX_IN==0 in the first IDLE cycle (the same cycle data_valid is high) starts the next frame immediately.
- No idle gap is required.

Input constraints
- Prescale and PAR_EN must be static outside IDLE. Behaviour for illegal Prescale is undefined.
- The deserializer shifts on deser_en && END, giving exactly DATA_WIDTH shifts per frame.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state enum rx_state_e (IDLE, START, DATA, PARITY, STOP);
  - legal prescale constants PRESC_8, PRESC_16, PRESC_32;
  - the DATA_WIDTH default.
- One natural sub-module: edge_bit_counter, holding the edge/bit counters with enable, wrap at Prescale-1 and clear. The FSM stays in uart_rx_ctrl.

Test Plan:
- Clean frame: Prescale=8, PAR_EN=1, even parity, data 0xA5, no errors, detection at t0 -> deser_en high t0+8..t0+71; data_valid single pulse at t0+88; P_DATA=0xA5.
- No parity: Prescale=16, PAR_EN=0, data 0x3C, detection at t0 -> par_chk_en never high; data_valid at t0+160; P_DATA=0x3C.
- Start glitch: Prescale=8, RX_IN low 2 cycles, strt_glitch=1 at edge 7 -> IDLE at t0+8; deser_en never asserted; no data_valid.
- Parity/stop error:
  - par_err=1 at PARITY END -> no data_valid; IDLE at t0+88.
  - Separately, stp_err=1 -> same result.
- Back-to-back: two frames 0x55 then 0xAA at Prescale=32, PAR_EN=0, second start bit low in the data_valid cycle -> two data_valid pulses exactly 320 cycles apart.
- Reset mid-DATA: RST=0 for one cycle at bit_count=4 -> all outputs 0 the next cycle; no data_valid; next frame received correctly.
